// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate data-cache controller.
// One word per line. Drives an external tag store {valid,dirty,tag} and data store
// (combinational read, clocked write) and a single-beat request/ack memory bus.
module cache_controller #(
   parameter int  ADDR_W    = 32,
   parameter int  OFFSET_W  = 2,
   parameter int  IDX_W     = 5,
   parameter int  DATA_W    = 32,
   localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W,
   localparam int TAG_MEM_W = TAG_W + 2
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   // CPU load/store port
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [DATA_W-1:0]    cpu_wdata,
   output logic [DATA_W-1:0]    cpu_rdata,
   output logic                 cpu_ack,
   output logic                 cpu_busy,
   // external memory bus
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ack,
   // tag and data stores
   output logic                 tag_we,
   output logic [IDX_W-1:0]     idx,
   output logic [TAG_MEM_W-1:0] tag_block_in,
   input  logic [TAG_MEM_W-1:0] tag_block_out,
   output logic                 data_we,
   output logic [DATA_W-1:0]    data_in,
   input  logic [DATA_W-1:0]    data_out
);

   typedef enum logic [2:0] {
      S_INIT      = 3'd0,
      S_IDLE      = 3'd1,
      S_COMPARE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_ALLOCATE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;

   // latched request fields (datapath, not reset)
   logic                req_we_q, req_we_d;
   logic [TAG_W-1:0]    req_tag_q, req_tag_d;
   logic [IDX_W-1:0]    req_idx_q, req_idx_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

   // registered outputs
   logic                cpu_ack_q, cpu_ack_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;

   // decoded view of the tag-store entry at idx
   logic                st_valid;
   logic                st_dirty;
   logic [TAG_W-1:0]    st_tag;
   logic                hit;

   // byte-offset bits play no part in a one-word line
   logic                unused_offset;

   assign st_valid      = tag_block_out[TAG_MEM_W-1];
   assign st_dirty      = tag_block_out[TAG_MEM_W-2];
   assign st_tag        = tag_block_out[TAG_W-1:0];
   assign hit           = st_valid && (st_tag == req_tag_q);
   assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

   // Next-state, store-write and registered-output decode for the controller FSM
   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      req_we_d     = req_we_q;
      req_tag_d    = req_tag_q;
      req_idx_d    = req_idx_q;
      req_wdata_d  = req_wdata_q;
      cpu_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      tag_we       = 1'b0;
      tag_block_in = '0;
      data_we      = 1'b0;
      data_in      = '0;
      idx          = (state_q == S_INIT) ? init_cnt_q : req_idx_q;

      case (state_q)
         S_INIT: begin
            // invalidate one line per cycle; CPU requests wait until the sweep ends
            tag_we       = 1'b1;
            tag_block_in = '0;
            init_cnt_d   = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            // a request still high during its own ack cycle is the old one
            if (cpu_req && !cpu_ack_q) begin
               req_we_d    = cpu_we;
               req_tag_d   = cpu_addr[ADDR_W-1 -: TAG_W];
               req_idx_d   = cpu_addr[OFFSET_W +: IDX_W];
               req_wdata_d = cpu_wdata;
               state_d     = S_COMPARE;
            end
         end

         S_COMPARE: begin
            if (hit) begin
               if (req_we_q) begin
                  data_we      = 1'b1;
                  data_in      = req_wdata_q;
                  tag_we       = 1'b1;
                  tag_block_in = {1'b1, 1'b1, req_tag_q};
               end else begin
                  cpu_rdata_d = data_out;
               end
               cpu_ack_d = 1'b1;
               state_d   = S_IDLE;
            end else if (st_valid && st_dirty) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_ALLOCATE;
            end
         end

         S_WRITEBACK: begin
            if (mem_ack) begin
               state_d = S_ALLOCATE;
            end
         end

         S_ALLOCATE: begin
            // refill lands clean; a pending store merges on the COMPARE re-pass
            if (mem_ack) begin
               data_we      = 1'b1;
               data_in      = mem_rdata;
               tag_we       = 1'b1;
               tag_block_in = {1'b1, 1'b0, req_tag_q};
               state_d      = S_COMPARE;
            end
         end

         default: begin
            state_d = S_INIT;
         end
      endcase

      // a reset cycle abandons whatever transaction is in flight
      if (iRST) begin
         tag_we  = 1'b0;
         data_we = 1'b0;
      end

      mem_req_d = (state_d == S_WRITEBACK) || (state_d == S_ALLOCATE);
      mem_we_d  = (state_d == S_WRITEBACK);
   end

   // State, control and registered-output flops; request fields carry no reset
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q     <= S_INIT;
         init_cnt_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
      end
      req_we_q    <= req_we_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_wdata_q <= req_wdata_d;
   end

   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_busy  = (state_q != S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   // writeback targets the resident line, refill the requested one
   assign mem_addr  = {((state_q == S_WRITEBACK) ? st_tag : req_tag_q), req_idx_q,
                       {OFFSET_W{1'b0}}};
   assign mem_wdata = data_out;

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenarios for the data-cache controller with
// behavioural tag/data stores and a task-driven memory bus responder.
module tb_cache_controller;

   localparam int ADDR_W = 32;
   localparam int IDX_W  = 5;
   localparam int DATA_W = 32;
   localparam int TMW    = 27;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_busy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              tag_we;
   logic [IDX_W-1:0]  idx;
   logic [TMW-1:0]    tag_block_in;
   logic [TMW-1:0]    tag_block_out;
   logic              data_we;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   int errors = 0;
   int checks = 0;

   cache_controller dut (
      .iCLK(clk), .iRST(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .tag_we(tag_we), .idx(idx), .tag_block_in(tag_block_in), .tag_block_out(tag_block_out),
      .data_we(data_we), .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   // behavioural stores and activity monitors
   logic [TMW-1:0]    tag_mem  [32];
   logic [DATA_W-1:0] data_mem [32];
   int                cycle = 0;
   int                tag_wr_cnt = 0;
   int                data_wr_cnt = 0;
   int                mem_req_cyc = 0;
   logic [TMW-1:0]    last_tag_wr = '0;
   logic [IDX_W-1:0]  last_tag_idx = '0;
   logic [DATA_W-1:0] last_data_wr = '0;

   assign tag_block_out = tag_mem[idx];
   assign data_out      = data_mem[idx];

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (tag_we) begin
         tag_mem[idx] <= tag_block_in;
         tag_wr_cnt   <= tag_wr_cnt + 1;
         last_tag_wr  <= tag_block_in;
         last_tag_idx <= idx;
      end
      if (data_we) begin
         data_mem[idx] <= data_in;
         data_wr_cnt   <= data_wr_cnt + 1;
         last_data_wr  <= data_in;
      end
      if (mem_req) mem_req_cyc <= mem_req_cyc + 1;
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int start);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      start     = cycle;
   endtask

   task automatic release_req();
      @(posedge clk);
      #1 cpu_req = 1'b0;
   endtask

   task automatic serve_bus(input int delay, input logic [31:0] rd, output logic we,
                            output logic [31:0] addr, output logic [31:0] wd, output bit ok);
      ok = 1'b0; we = 1'b0; addr = '0; wd = '0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (mem_req) ok = 1'b1;
      end
      if (ok) begin
         we   = mem_we;
         addr = mem_addr;
         wd   = mem_wdata;
         repeat (delay) @(posedge clk);
         #1 mem_ack = 1'b1;
         mem_rdata = rd;
         @(posedge clk);
         #1 mem_ack = 1'b0;
         mem_rdata = '0;
      end
   endtask

   task automatic wait_ack(input int start, output int lat, output logic [31:0] rd, output bit ok);
      ok = 1'b0; lat = 0; rd = '0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (cpu_ack) begin
            ok  = 1'b1;
            lat = cycle - start;
            rd  = cpu_rdata;
         end
      end
   endtask

   task automatic test_reset();
      int t0;
      int bad;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      t0 = tag_wr_cnt;
      checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", cpu_busy); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: got req=%b we=%b want 0 0", mem_req, mem_we); end
      checks++; if (data_we !== 1'b0) begin errors++; $display("FAIL reset_data_we: got %b want 0", data_we); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) @(negedge clk);
         if (tag_we !== 1'b1 || idx !== 5'(i) || tag_block_in !== '0 || cpu_busy !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL init_sweep: got %0d bad cycles want 0", bad); end
      @(negedge clk);
      checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL init_done_busy: got %b want 0", cpu_busy); end
      checks++; if (tag_we !== 1'b0) begin errors++; $display("FAIL init_done_tag_we: got %b want 0", tag_we); end
      checks++; if (tag_wr_cnt - t0 !== 32) begin errors++; $display("FAIL init_tag_writes: got %0d want 32", tag_wr_cnt - t0); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_miss();
      int start, lat, td, dd;
      logic we;
      logic [31:0] a, wd, rd;
      bit ok;
      td = tag_wr_cnt; dd = data_wr_cnt;
      issue(1'b0, 32'h0000_0100, 32'h0, start);
      serve_bus(3, 32'hDEAD_BEEF, we, a, wd, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_bus_req: got timeout want mem_req"); end
      checks++; if (we !== 1'b0 || a !== 32'h0000_0100) begin errors++; $display("FAIL miss_refill: got we=%b addr=%h want 0 00000100", we, a); end
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 7) begin errors++; $display("FAIL miss_latency: got ok=%b lat=%0d want 1 7", ok, lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata: got %h want deadbeef", rd); end
      checks++; if (tag_wr_cnt - td !== 1 || last_tag_wr !== 27'h400_0002 || last_tag_idx !== 5'd0) begin errors++; $display("FAIL miss_tag: got n=%0d tag=%h idx=%0d want 1 4000002 0", tag_wr_cnt - td, last_tag_wr, last_tag_idx); end
      checks++; if (data_wr_cnt - dd !== 1 || last_data_wr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data: got n=%0d d=%h want 1 deadbeef", data_wr_cnt - dd, last_data_wr); end
      release_req();
   endtask

   task automatic test_read_hit();
      int start, lat, md, td, dd;
      logic [31:0] rd;
      bit ok;
      md = mem_req_cyc; td = tag_wr_cnt; dd = data_wr_cnt;
      issue(1'b0, 32'h0000_0100, 32'h0, start);
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 2) begin errors++; $display("FAIL hit_latency: got ok=%b lat=%0d want 1 2", ok, lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
      checks++; if (mem_req_cyc - md !== 0 || tag_wr_cnt - td !== 0 || data_wr_cnt - dd !== 0) begin errors++; $display("FAIL hit_quiet: got mem=%0d tag=%0d data=%0d want 0 0 0", mem_req_cyc - md, tag_wr_cnt - td, data_wr_cnt - dd); end
      release_req();
   endtask

   task automatic test_write_hit();
      int start, lat, md, td, dd;
      logic [31:0] rd;
      bit ok;
      md = mem_req_cyc; td = tag_wr_cnt; dd = data_wr_cnt;
      issue(1'b1, 32'h0000_0100, 32'h1234_5678, start);
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 2) begin errors++; $display("FAIL whit_latency: got ok=%b lat=%0d want 1 2", ok, lat); end
      checks++; if (data_wr_cnt - dd !== 1 || last_data_wr !== 32'h1234_5678) begin errors++; $display("FAIL whit_data: got n=%0d d=%h want 1 12345678", data_wr_cnt - dd, last_data_wr); end
      checks++; if (tag_wr_cnt - td !== 1 || last_tag_wr !== 27'h600_0002) begin errors++; $display("FAIL whit_tag: got n=%0d tag=%h want 1 6000002", tag_wr_cnt - td, last_tag_wr); end
      checks++; if (mem_req_cyc - md !== 0) begin errors++; $display("FAIL whit_bus: got %0d req cycles want 0", mem_req_cyc - md); end
      release_req();
   endtask

   task automatic test_dirty_miss();
      int start, lat;
      logic we;
      logic [31:0] a, wd, rd;
      bit ok;
      issue(1'b0, 32'h0000_1100, 32'h0, start);
      serve_bus(2, 32'h0, we, a, wd, ok);
      checks++; if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h0000_0100) begin errors++; $display("FAIL wb_req: got ok=%b we=%b addr=%h want 1 1 00000100", ok, we, a); end
      checks++; if (wd !== 32'h1234_5678) begin errors++; $display("FAIL wb_data: got %h want 12345678", wd); end
      serve_bus(1, 32'hCAFE_F00D, we, a, wd, ok);
      checks++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0000_1100) begin errors++; $display("FAIL dm_refill: got ok=%b we=%b addr=%h want 1 0 00001100", ok, we, a); end
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 8) begin errors++; $display("FAIL dm_latency: got ok=%b lat=%0d want 1 8", ok, lat); end
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL dm_rdata: got %h want cafef00d", rd); end
      checks++; if (last_tag_wr !== 27'h400_0022) begin errors++; $display("FAIL dm_tag: got %h want 4000022", last_tag_wr); end
      release_req();
   endtask

   task automatic test_back_to_back();
      int start, lat, md;
      logic [31:0] rd;
      bit ok;
      md = mem_req_cyc;
      issue(1'b0, 32'h0000_1100, 32'h0, start);
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 2 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_first: got ok=%b lat=%0d rd=%h want 1 2 cafef00d", ok, lat, rd); end
      @(negedge clk);
      checks++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ack=%b busy=%b want 0 0", cpu_ack, cpu_busy); end
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 5 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_second: got ok=%b lat=%0d rd=%h want 1 5 cafef00d", ok, lat, rd); end
      checks++; if (mem_req_cyc - md !== 0) begin errors++; $display("FAIL b2b_bus: got %0d req cycles want 0", mem_req_cyc - md); end
      release_req();
   endtask

   task automatic test_ack_ignored();
      int td, dd;
      td = tag_wr_cnt; dd = data_wr_cnt;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      checks++; if (cpu_busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack_state: got busy=%b req=%b want 0 0", cpu_busy, mem_req); end
      checks++; if (tag_wr_cnt - td !== 0 || data_wr_cnt - dd !== 0) begin errors++; $display("FAIL stray_ack_writes: got tag=%0d data=%0d want 0 0", tag_wr_cnt - td, data_wr_cnt - dd); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_alloc();
      int start, dd, bad;
      bit ok;
      issue(1'b0, 32'h0000_0204, 32'h0, start);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (mem_req) ok = 1'b1;
      end
      checks++; if (ok !== 1'b1 || mem_addr !== 32'h0000_0204) begin errors++; $display("FAIL ra_alloc: got ok=%b addr=%h want 1 00000204", ok, mem_addr); end
      dd = data_wr_cnt;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ra_mem_req: got %b want 0", mem_req); end
      checks++; if (tag_we !== 1'b1 || idx !== 5'd0 || cpu_busy !== 1'b1) begin errors++; $display("FAIL ra_init: got tag_we=%b idx=%0d busy=%b want 1 0 1", tag_we, idx, cpu_busy); end
      bad = 0;
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         if (tag_we !== 1'b1 || idx !== 5'(i)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL ra_sweep: got %0d bad cycles want 0", bad); end
      @(negedge clk);
      checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL ra_done: got busy=%b want 0", cpu_busy); end
      checks++; if (data_wr_cnt - dd !== 0) begin errors++; $display("FAIL ra_no_data: got %0d data writes want 0", data_wr_cnt - dd); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_miss();
      int start, lat, td, dd;
      logic we;
      logic [31:0] a, wd, rd;
      bit ok;
      td = tag_wr_cnt; dd = data_wr_cnt;
      issue(1'b1, 32'h0000_0208, 32'hA5A5_A5A5, start);
      serve_bus(1, 32'h1111_1111, we, a, wd, ok);
      checks++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0000_0208) begin errors++; $display("FAIL wm_refill: got ok=%b we=%b addr=%h want 1 0 00000208", ok, we, a); end
      wait_ack(start, lat, rd, ok);
      checks++; if (ok !== 1'b1 || lat !== 5) begin errors++; $display("FAIL wm_latency: got ok=%b lat=%0d want 1 5", ok, lat); end
      checks++; if (data_wr_cnt - dd !== 2 || last_data_wr !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wm_data: got n=%0d d=%h want 2 a5a5a5a5", data_wr_cnt - dd, last_data_wr); end
      checks++; if (tag_wr_cnt - td !== 2 || last_tag_wr !== 27'h600_0004 || last_tag_idx !== 5'd2) begin errors++; $display("FAIL wm_tag: got n=%0d tag=%h idx=%0d want 2 6000004 2", tag_wr_cnt - td, last_tag_wr, last_tag_idx); end
      release_req();
   endtask

   initial begin
      test_reset();
      test_load_miss();
      test_read_hit();
      test_write_hit();
      test_dirty_miss();
      test_back_to_back();
      test_ack_ignored();
      test_reset_alloc();
      test_write_miss();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
